// File: rtl/load_byte_select_pkg.sv
// Shared encodings and helpers for the load byte-select stage.
package load_byte_select_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // Natural alignment check; the reserved size is never aligned.
  function automatic logic is_aligned(input size_t size, input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (offset[0] == 1'b0);
      SZ_WORD: ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_byte_select_lane_extract.sv
// Selects the addressed little-endian lane of a word and right-justifies it,
// zero-filling the bits above the lane.
import load_byte_select_pkg::*;

module load_byte_select_lane_extract (
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        offset,
  input  size_t             size,
  output logic [WORD_W-1:0] lane
);

  // Lane mux driven purely by size and offset.
  always_comb begin
    lane = '0;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    lane[7:0] = word[7:0];
          2'd1:    lane[7:0] = word[15:8];
          2'd2:    lane[7:0] = word[23:16];
          default: lane[7:0] = word[31:24];
        endcase
      end
      SZ_HALF: lane[15:0] = offset[1] ? word[31:16] : word[15:0];
      SZ_WORD: lane = word;
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/load_byte_select.sv
// Load stage: issues one word-aligned read, waits for the response with a
// timeout, extracts the requested lane and holds it until the consumer takes it.
import load_byte_select_pkg::*;

module load_byte_select #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state;
  size_t              size_q;
  logic [1:0]         offset_q;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  lane;

  assign req_ready = (state == ST_IDLE);

  load_byte_select_lane_extract u_lane (
    .word   (mem_rd_data),
    .offset (offset_q),
    .size   (size_q),
    .lane   (lane)
  );

  // Request FSM with timeout counter and one-entry result buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      size_q    <= SZ_BYTE;
      offset_q  <= '0;
      cnt       <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_addr <= {req_addr[31:2], 2'b00};
            offset_q <= req_addr[1:0];
            size_q   <= size_t'(req_size);
            cnt      <= '0;
            if (is_aligned(size_t'(req_size), req_addr[1:0])) begin
              state     <= ST_WAIT;
              mem_rd_en <= 1'b1;
            end else begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_data  <= '0;
            end
          end
        end
        ST_WAIT: begin
          // A response in the same cycle as the final count takes priority.
          if (mem_rd_valid) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_data  <= lane;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_data  <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_byte_select.md
Name: load_byte_select

Overview:
- Memory-side load stage of the 32-bit datapath, directly upstream of the byte/halfword extension units.
- Accepts a load request (address, size), issues one word-aligned read to data memory and waits a variable number of cycles for the response.
- Extracts the addressed byte, halfword or word lane, right-justifies it with all bits above the lane zero, and holds it in a one-entry output buffer until the consumer takes it.
- Sign or zero extension is done downstream, not here.

Parameters:
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT_MEM before the request completes with error. Legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  load request present
- req_ready  output  1  block can accept a request; equals (state==IDLE)
- req_addr  input  32  byte address
- req_size  input  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as misaligned)
- mem_rd_en  output  1  one-cycle read strobe to data memory
- mem_addr  output  32  {req_addr[31:2],2'b00}, held stable while in WAIT_MEM
- mem_rd_valid  input  1  memory read data valid
- mem_rd_data  input  32  memory read word, little-endian lanes
- out_valid  output  1  result buffer full
- out_ready  input  1  consumer accepts the result
- out_data  output  32  right-justified lane, upper bits zero
- out_err  output  1  misaligned, reserved size, or timeout

Behaviour:
- Reset values: state=IDLE; req_ready=1 once reset is low; mem_rd_en=0; mem_addr=0; out_valid=0; out_data=0; out_err=0; timeout counter=0.
- States: IDLE, WAIT_MEM, HOLD.
- IDLE, when req_valid&req_ready:
  - Latch addr, size and offset=addr[1:0].
  - Alignment is legal when: byte at any offset; half with offset[0]=0; word with offset=00.
  - Legal request: go to WAIT_MEM; mem_rd_en=1 for exactly the first WAIT_MEM cycle.
  - Illegal request: go directly to HOLD with out_err=1, out_data=0, and no memory access.
- WAIT_MEM:
  - mem_rd_valid may be high in the same cycle as mem_rd_en (zero-latency memory) or any later cycle.
  - On the edge where mem_rd_valid=1: capture the lane into out_data, set out_err=0, go to HOLD.
  - Lane selection. Byte: offset 0 gives bits[7:0], 1 gives [15:8], 2 gives [23:16], 3 gives [31:24]. Half: offset 0 gives [15:0], 2 gives [31:16]. Word: all 32 bits.
  - The counter increments every WAIT_MEM cycle without mem_rd_valid. When the counter reaches TIMEOUT_CYC: go to HOLD with out_err=1, out_data=0.
  - mem_rd_valid arriving after a timeout, or while in IDLE or HOLD, is ignored.
  - mem_rd_valid wins over timeout in the same cycle.
- HOLD:
  - out_valid=1; out_data and out_err are stable until handshake.
  - On out_valid&out_ready: return to IDLE, out_valid=0 the next cycle.
  - req_ready=0 throughout HOLD, so there is no request overlap.
- Latency:
  - Accept edge to out_valid is 2 cycles with zero-latency memory, or 1 + memory latency otherwise.
  - Misaligned request: out_valid 1 cycle after accept.
  - Minimum throughput is one load per 3 cycles.
- Reset mid-operation (any state) returns to IDLE next edge:
  - out_valid=0 and mem_rd_en=0 immediately after the reset edge.
  - The outstanding memory response is discarded.
- The counter clears on every entry to WAIT_MEM. Its width is clog2(TIMEOUT_CYC+1).

Decomposition:
- Shared package holds:
  - Size encodings SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD.
  - State encodings ST_IDLE / ST_WAIT / ST_HOLD.
  - Word width constant 32.
- One natural combinational sub-module, lane_extract: inputs word, offset, size; output right-justified 32-bit value.
- The FSM, counter and buffer stay in the top module.

Test Plan:
- Byte load, addr=0x0000_1003, memory returns 0xAABBCCDD one cycle after mem_rd_en. Required: mem_addr=0x0000_1000, mem_rd_en high for 1 cycle, out_data=0x0000_00AA, out_err=0.
- Half load, addr=0x0000_2002, zero-latency memory returning 0x8765_4321. Required: out_valid 2 cycles after accept, out_data=0x0000_8765.
- Half load at addr=0x0000_0001, and word load at addr=0x0000_0006. Required: no mem_rd_en; out_valid one cycle after accept; out_err=1; out_data=0.
- TIMEOUT_CYC=4 and memory never responds. Required: out_err=1 after 4 WAIT_MEM cycles; a late mem_rd_valid is ignored; next request behaves normally.
- out_ready held low for 5 cycles after a word load returning 0x1234_5678. Required: out_data stable at 0x1234_5678, req_ready=0 throughout; IDLE the cycle after out_ready=1.
- Reset asserted during WAIT_MEM, then mem_rd_valid arrives the next cycle. Required: out_valid stays 0; next request completes with correct data.
